alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
ID/EX pipeline stage that sits directly upstream of the 32-bit ALU. It captures a decoded RV32I instruction and forwards bypass data from EX/MEM and MEM/WB. Each cycle it registers the ALU operands X/Y and the 4-bit ALU select. It also carries rd, write-enable, store data and PC down the pipeline, under stall/flush control.

Parameters:
XLEN, 32, datapath width of operands, immediates, PC and forwarded data
REG_ADDR_W, 5, register index width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous active-high reset
in_valid  input  1  decode stage presents a valid instruction
in_ready  output  1  stage can accept this cycle; equals !stall
stall  input  1  hazard unit: hold registered contents
flush  input  1  branch/jump redirect: kill captured and incoming instruction
opcode  input  7  instruction opcode
funct3  input  3  instruction funct3
funct7b5  input  1  instruction bit 30
rs1_addr  input  REG_ADDR_W  source 1 index
rs2_addr  input  REG_ADDR_W  source 2 index
rs1_data  input  XLEN  register file read 1
rs2_data  input  XLEN  register file read 2
imm  input  XLEN  sign-extended immediate from decoder
pc  input  XLEN  instruction PC
rd_addr  input  REG_ADDR_W  destination index
exmem_wr_en  input  1  EX/MEM writes a register
exmem_rd  input  REG_ADDR_W  EX/MEM destination
exmem_data  input  XLEN  EX/MEM result
memwb_wr_en  input  1  MEM/WB writes a register
memwb_rd  input  REG_ADDR_W  MEM/WB destination
memwb_data  input  XLEN  MEM/WB result
ex_valid  output  1  registered instruction valid
alu_x  output  XLEN  registered ALU operand X
alu_y  output  XLEN  registered ALU operand Y
alu_select  output  4  registered ALU select
ex_rd  output  REG_ADDR_W  registered destination
ex_wr_en  output  1  registered register-write enable
ex_store_data  output  XLEN  registered forwarded rs2 value (stores)
ex_pc  output  XLEN  registered PC
ex_illegal  output  1  registered illegal-instruction flag

Behaviour:
- Reset: every output register is 0, and ex_valid=0. Reset has priority over flush and stall, and takes effect mid-stall.
- Priority each edge: reset > flush > stall > capture.
- flush: ex_valid<=0, ex_wr_en<=0, ex_illegal<=0. Data registers are don't-care. Flush wins even while stall=1.
- stall (no flush): all registers hold. The in_valid instruction is not consumed; the decoder must hold it.
- Capture: when !stall && !flush, latency is 1 cycle. ex_valid<=in_valid. If in_valid=0, ex_wr_en<=0 and ex_illegal<=0.
- Forwarding, done at capture for each source s:
  - If the address is 0, use 0.
  - Otherwise, if exmem_wr_en and exmem_rd==addr, use exmem_data.
  - Otherwise, if memwb_wr_en and memwb_rd==addr, use memwb_data.
  - Otherwise use the register file data.
  - EX/MEM beats MEM/WB when both match.
- Operand and select by opcode. Select encoding: add 0000, sub 1000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, sra 1101, or 0110, and 0111.
  - OP 0110011: X=rs1f, Y=rs2f, select={funct7b5,funct3}. funct7b5=1 is legal only for funct3 000/101; otherwise illegal. wr_en=1.
  - OP-IMM 0010011: X=rs1f, Y=imm. select bit3=funct7b5 only when funct3=101, else 0. wr_en=1.
  - LOAD 0000011: X=rs1f, Y=imm, add, wr_en=1.
  - STORE 0100011: X=rs1f, Y=imm, add, wr_en=0, ex_store_data=rs2f.
  - BRANCH 1100011: X=rs1f, Y=rs2f, wr_en=0. funct3 00x selects sub, 10x selects slt, 11x selects sltu; 01x is illegal.
  - LUI 0110111: X=0, Y=imm, add, wr_en=1.
  - AUIPC 0010111: X=pc, Y=imm, add, wr_en=1.
  - JAL 1101111 / JALR 1100111: X=pc, Y=4, add (link value), wr_en=1.
  - Any other opcode: ex_illegal=1, wr_en=0, select 0000, X=Y=0.
- ex_wr_en is forced 0 when rd_addr==0.
- Outputs are pure registers; there is no combinational path from inputs to outputs except in_ready.

Test Plan:
- Reset then ADD x3,x1,x2 (rs1_data=5, rs2_data=7, no forwarding) -> after 1 edge: ex_valid=1, alu_x=5, alu_y=7, alu_select=0000, ex_rd=3, ex_wr_en=1.
- SUB with exmem (rd=1, data=0x100) and memwb (rd=1, data=0x200) both writing x1, rs2=x0 with rs2_data=0xDEAD -> alu_x=0x100, alu_y=0, select=1000.
- SRAI imm=3, funct7b5=1, funct3=101 -> select=1101, alu_y=3. Then SLLI with funct7b5=0 -> select=0001. R-type funct3=100 with funct7b5=1 -> ex_illegal=1, ex_wr_en=0.
- Capture AUIPC pc=0x1000 imm=0x2000, then stall=1 for 3 cycles while inputs change -> outputs hold alu_x=0x1000, alu_y=0x2000 and in_ready=0. Then flush=1 with stall=1 -> ex_valid=0 next edge.
- BLTU rs1=0xFFFFFFFF, rs2=1 -> select=0011, ex_wr_en=0. JAL pc=0x40 rd=1 -> alu_x=0x40, alu_y=4, select=0000.
- Assert reset during a stall with ex_valid=1 -> all outputs are 0 next edge.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: forwards EX/MEM and MEM/WB results into the source
// operands, selects ALU operands and function, and registers everything
// toward EX under reset/flush/stall control.
module alu_operand_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [6:0]            opcode,
   input  logic [2:0]            funct3,
   input  logic                  funct7b5,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   input  logic [XLEN-1:0]       rs1_data,
   input  logic [XLEN-1:0]       rs2_data,
   input  logic [XLEN-1:0]       imm,
   input  logic [XLEN-1:0]       pc,
   input  logic [REG_ADDR_W-1:0] rd_addr,
   input  logic                  exmem_wr_en,
   input  logic [REG_ADDR_W-1:0] exmem_rd,
   input  logic [XLEN-1:0]       exmem_data,
   input  logic                  memwb_wr_en,
   input  logic [REG_ADDR_W-1:0] memwb_rd,
   input  logic [XLEN-1:0]       memwb_data,
   output logic                  ex_valid,
   output logic [XLEN-1:0]       alu_x,
   output logic [XLEN-1:0]       alu_y,
   output logic [3:0]            alu_select,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  ex_wr_en,
   output logic [XLEN-1:0]       ex_store_data,
   output logic [XLEN-1:0]       ex_pc,
   output logic                  ex_illegal
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [XLEN-1:0] ZERO_X = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] FOUR_X = {{(XLEN-3){1'b0}}, 3'b100};
   localparam logic [REG_ADDR_W-1:0] ZERO_R = {REG_ADDR_W{1'b0}};

   // Bypass mux: x0 reads zero, the younger EX/MEM result beats MEM/WB.
   function automatic logic [XLEN-1:0] fwd_value(
      input logic [REG_ADDR_W-1:0] addr,
      input logic [XLEN-1:0]       rf_data,
      input logic                  em_we,
      input logic [REG_ADDR_W-1:0] em_rd,
      input logic [XLEN-1:0]       em_data,
      input logic                  mw_we,
      input logic [REG_ADDR_W-1:0] mw_rd,
      input logic [XLEN-1:0]       mw_data
   );
      logic [XLEN-1:0] val;
      if (addr == ZERO_R) begin
         val = ZERO_X;
      end else if (em_we && (em_rd == addr)) begin
         val = em_data;
      end else if (mw_we && (mw_rd == addr)) begin
         val = mw_data;
      end else begin
         val = rf_data;
      end
      return val;
   endfunction

   logic [XLEN-1:0]       rs1_fwd_s, rs2_fwd_s;
   logic [XLEN-1:0]       dec_x_s, dec_y_s;
   logic [3:0]            dec_sel_s;
   logic                  dec_wr_s, dec_ill_s;

   logic                  ex_valid_d, ex_valid_q;
   logic [XLEN-1:0]       alu_x_d, alu_x_q;
   logic [XLEN-1:0]       alu_y_d, alu_y_q;
   logic [3:0]            alu_select_d, alu_select_q;
   logic [REG_ADDR_W-1:0] ex_rd_d, ex_rd_q;
   logic                  ex_wr_en_d, ex_wr_en_q;
   logic [XLEN-1:0]       ex_store_data_d, ex_store_data_q;
   logic [XLEN-1:0]       ex_pc_d, ex_pc_q;
   logic                  ex_illegal_d, ex_illegal_q;

   // Resolve both source operands through the bypass network.
   always_comb begin
      rs1_fwd_s = fwd_value(rs1_addr, rs1_data, exmem_wr_en, exmem_rd, exmem_data,
                            memwb_wr_en, memwb_rd, memwb_data);
      rs2_fwd_s = fwd_value(rs2_addr, rs2_data, exmem_wr_en, exmem_rd, exmem_data,
                            memwb_wr_en, memwb_rd, memwb_data);
   end

   // Decode opcode into ALU operands, ALU select, write enable and illegal flag.
   always_comb begin
      dec_x_s   = ZERO_X;
      dec_y_s   = ZERO_X;
      dec_sel_s = 4'b0000;
      dec_wr_s  = 1'b0;
      dec_ill_s = 1'b0;
      case (opcode)
         OPC_OP: begin
            dec_x_s   = rs1_fwd_s;
            dec_y_s   = rs2_fwd_s;
            dec_sel_s = {funct7b5, funct3};
            // Only SUB and SRA use bit 30 among the register-register ops.
            if (funct7b5 && (funct3 != 3'b000) && (funct3 != 3'b101)) begin
               dec_ill_s = 1'b1;
               dec_wr_s  = 1'b0;
            end else begin
               dec_ill_s = 1'b0;
               dec_wr_s  = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            dec_x_s  = rs1_fwd_s;
            dec_y_s  = imm;
            dec_wr_s = 1'b1;
            // Bit 30 is part of the immediate except for the SRLI/SRAI pair.
            if (funct3 == 3'b101) begin
               dec_sel_s = {funct7b5, funct3};
            end else begin
               dec_sel_s = {1'b0, funct3};
            end
         end
         OPC_LOAD: begin
            dec_x_s  = rs1_fwd_s;
            dec_y_s  = imm;
            dec_wr_s = 1'b1;
         end
         OPC_STORE: begin
            dec_x_s  = rs1_fwd_s;
            dec_y_s  = imm;
         end
         OPC_BRANCH: begin
            dec_x_s = rs1_fwd_s;
            dec_y_s = rs2_fwd_s;
            case (funct3[2:1])
               2'b00:   dec_sel_s = 4'b1000;
               2'b10:   dec_sel_s = 4'b0010;
               2'b11:   dec_sel_s = 4'b0011;
               default: dec_ill_s = 1'b1;
            endcase
         end
         OPC_LUI: begin
            dec_y_s  = imm;
            dec_wr_s = 1'b1;
         end
         OPC_AUIPC: begin
            dec_x_s  = pc;
            dec_y_s  = imm;
            dec_wr_s = 1'b1;
         end
         OPC_JAL, OPC_JALR: begin
            dec_x_s  = pc;
            dec_y_s  = FOUR_X;
            dec_wr_s = 1'b1;
         end
         default: begin
            dec_ill_s = 1'b1;
         end
      endcase
      // Writes to x0 are discarded.
      if (rd_addr == ZERO_R) begin
         dec_wr_s = 1'b0;
      end else begin
         dec_wr_s = dec_wr_s;
      end
   end

   // Next-state selection: flush beats stall, stall beats capture.
   always_comb begin
      ex_valid_d      = ex_valid_q;
      alu_x_d         = alu_x_q;
      alu_y_d         = alu_y_q;
      alu_select_d    = alu_select_q;
      ex_rd_d         = ex_rd_q;
      ex_wr_en_d      = ex_wr_en_q;
      ex_store_data_d = ex_store_data_q;
      ex_pc_d         = ex_pc_q;
      ex_illegal_d    = ex_illegal_q;
      if (flush) begin
         ex_valid_d   = 1'b0;
         ex_wr_en_d   = 1'b0;
         ex_illegal_d = 1'b0;
      end else if (stall) begin
         ex_valid_d = ex_valid_q;
      end else begin
         ex_valid_d      = in_valid;
         alu_x_d         = dec_x_s;
         alu_y_d         = dec_y_s;
         alu_select_d    = dec_sel_s;
         ex_rd_d         = rd_addr;
         ex_wr_en_d      = in_valid & dec_wr_s;
         ex_store_data_d = rs2_fwd_s;
         ex_pc_d         = pc;
         ex_illegal_d    = in_valid & dec_ill_s;
      end
   end

   // Pipeline register with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid_q      <= 1'b0;
         alu_x_q         <= ZERO_X;
         alu_y_q         <= ZERO_X;
         alu_select_q    <= 4'b0000;
         ex_rd_q         <= ZERO_R;
         ex_wr_en_q      <= 1'b0;
         ex_store_data_q <= ZERO_X;
         ex_pc_q         <= ZERO_X;
         ex_illegal_q    <= 1'b0;
      end else begin
         ex_valid_q      <= ex_valid_d;
         alu_x_q         <= alu_x_d;
         alu_y_q         <= alu_y_d;
         alu_select_q    <= alu_select_d;
         ex_rd_q         <= ex_rd_d;
         ex_wr_en_q      <= ex_wr_en_d;
         ex_store_data_q <= ex_store_data_d;
         ex_pc_q         <= ex_pc_d;
         ex_illegal_q    <= ex_illegal_d;
      end
   end

   assign in_ready      = ~stall;
   assign ex_valid      = ex_valid_q;
   assign alu_x         = alu_x_q;
   assign alu_y         = alu_y_q;
   assign alu_select    = alu_select_q;
   assign ex_rd         = ex_rd_q;
   assign ex_wr_en      = ex_wr_en_q;
   assign ex_store_data = ex_store_data_q;
   assign ex_pc         = ex_pc_q;
   assign ex_illegal    = ex_illegal_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: the driver pushes the expected
// registered state for each edge, the monitor pops and compares after it.
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, stall, flush;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr, exmem_rd, memwb_rd;
   logic [31:0] rs1_data, rs2_data, imm, pc, exmem_data, memwb_data;
   logic        exmem_wr_en, memwb_wr_en;
   logic        ex_valid, ex_wr_en, ex_illegal;
   logic [31:0] alu_x, alu_y, ex_store_data, ex_pc;
   logic [3:0]  alu_select;
   logic [4:0]  ex_rd;

   alu_operand_stage dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .stall(stall), .flush(flush), .opcode(opcode), .funct3(funct3),
      .funct7b5(funct7b5), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
      .rd_addr(rd_addr), .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd),
      .exmem_data(exmem_data), .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd),
      .memwb_data(memwb_data), .ex_valid(ex_valid), .alu_x(alu_x),
      .alu_y(alu_y), .alu_select(alu_select), .ex_rd(ex_rd),
      .ex_wr_en(ex_wr_en), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
      .ex_illegal(ex_illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        full;
      logic        valid;
      logic [31:0] x;
      logic [31:0] y;
      logic [3:0]  sel;
      logic [4:0]  rd;
      logic        wr;
      logic [31:0] sd;
      logic [31:0] pcv;
      logic        ill;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
      end
   endtask

   function automatic exp_t mk(input logic full, input logic valid, input logic [31:0] x,
                               input logic [31:0] y, input logic [3:0] sel, input logic [4:0] rd,
                               input logic wr, input logic [31:0] sd, input logic [31:0] pcv,
                               input logic ill);
      exp_t e;
      e.full = full; e.valid = valid; e.x = x; e.y = y; e.sel = sel; e.rd = rd;
      e.wr = wr; e.sd = sd; e.pcv = pcv; e.ill = ill;
      return e;
   endfunction

   task automatic issue(input string nm, input exp_t e);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic clear();
      reset = 1'b0; in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
      opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
      rs1_addr = 5'd0; rs2_addr = 5'd0; rd_addr = 5'd0;
      rs1_data = 32'h0; rs2_data = 32'h0; imm = 32'h0; pc = 32'h0;
      exmem_wr_en = 1'b0; exmem_rd = 5'd0; exmem_data = 32'h0;
      memwb_wr_en = 1'b0; memwb_rd = 5'd0; memwb_data = 32'h0;
   endtask

   task automatic set_rr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [4:0] r1, input logic [31:0] d1,
                         input logic [4:0] r2, input logic [31:0] d2, input logic [4:0] rd);
      opcode = op; funct3 = f3; funct7b5 = f7;
      rs1_addr = r1; rs1_data = d1; rs2_addr = r2; rs2_data = d2; rd_addr = rd;
   endtask

   // Monitor: after every rising edge, compare DUT state to the next expectation.
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk({nm, ".ex_valid"},   {31'd0, ex_valid},   {31'd0, e.valid});
            chk({nm, ".ex_wr_en"},   {31'd0, ex_wr_en},   {31'd0, e.wr});
            chk({nm, ".ex_illegal"}, {31'd0, ex_illegal}, {31'd0, e.ill});
            if (e.full) begin
               chk({nm, ".alu_x"},         alu_x,                 e.x);
               chk({nm, ".alu_y"},         alu_y,                 e.y);
               chk({nm, ".alu_select"},    {28'd0, alu_select},   {28'd0, e.sel});
               chk({nm, ".ex_rd"},         {27'd0, ex_rd},        {27'd0, e.rd});
               chk({nm, ".ex_store_data"}, ex_store_data,         e.sd);
               chk({nm, ".ex_pc"},         ex_pc,                 e.pcv);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   // Driver: directed vectors with hand-computed expectations.
   initial begin
      exp_t auipc_e;
      clear();
      reset = 1'b1; opcode = 7'b0010111; imm = 32'h1234; pc = 32'h99; rd_addr = 5'd7;
      @(negedge clk);
      issue("reset", mk(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0));

      @(negedge clk); clear();
      set_rr(7'b0110011, 3'b000, 1'b0, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3); pc = 32'h10;
      issue("add", mk(1'b1, 1'b1, 32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 32'd7, 32'h10, 1'b0));
      #1 chk("in_ready_idle", {31'd0, in_ready}, 32'd1);

      @(negedge clk); clear();
      set_rr(7'b0110011, 3'b000, 1'b1, 5'd1, 32'h55, 5'd0, 32'hDEAD, 5'd4); pc = 32'h14;
      exmem_wr_en = 1'b1; exmem_rd = 5'd1; exmem_data = 32'h100;
      memwb_wr_en = 1'b1; memwb_rd = 5'd1; memwb_data = 32'h200;
      issue("sub_fwd", mk(1'b1, 1'b1, 32'h100, 32'h0, 4'b1000, 5'd4, 1'b1, 32'h0, 32'h14, 1'b0));

      @(negedge clk); clear();
      set_rr(7'b0110011, 3'b000, 1'b0, 5'd6, 32'd1, 5'd7, 32'd2, 5'd5); pc = 32'h18;
      exmem_wr_en = 1'b0; exmem_rd = 5'd6; exmem_data = 32'h666;
      memwb_wr_en = 1'b1; memwb_rd = 5'd7; memwb_data = 32'h77;
      issue("add_memwb", mk(1'b1, 1'b1, 32'd1, 32'h77, 4'b0000, 5'd5, 1'b1, 32'h77, 32'h18, 1'b0));

      @(negedge clk); clear();
      set_rr(7'b0010011, 3'b101, 1'b1, 5'd9, 32'h80000000, 5'd0, 32'h0, 5'd8); imm = 32'd3; pc = 32'h1C;
      issue("srai", mk(1'b1, 1'b1, 32'h80000000, 32'd3, 4'b1101, 5'd8, 1'b1, 32'h0, 32'h1C, 1'b0));

      @(negedge clk); clear();
      set_rr(7'b0010011, 3'b001, 1'b0, 5'd9, 32'h1, 5'd0, 32'h0, 5'd8); imm = 32'd2; pc = 32'h20;
      issue("slli", mk(1'b1, 1'b1, 32'h1, 32'd2, 4'b0001, 5'd8, 1'b1, 32'h0, 32'h20, 1'b0));

      @(negedge clk); clear();
      set_rr(7'b0010011, 3'b000, 1'b1, 5'd2, 32'h10, 5'd0, 32'h0, 5'd1); imm = 32'hFFFFFFFF; pc = 32'h24;
      issue("addi_neg", mk(1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 5'd1, 1'b1, 32'h0, 32'h24, 1'b0));

      @(negedge clk); clear();
      set_rr(7'b0110011, 3'b100, 1'b1, 5'd1, 32'h3, 5'd2, 32'h4, 5'd6);
      issue("r_illegal", mk(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1));

      @(negedge clk); clear();
      set_rr(7'b0110011, 3'b111, 1'b0, 5'd1, 32'hF0, 5'd2, 32'h3C, 5'd0); pc = 32'h2C;
      issue("and_rd0", mk(1'b1, 1'b1, 32'hF0, 32'h3C, 4'b0111, 5'd0, 1'b0, 32'h3C, 32'h2C, 1'b0));

      @(negedge clk); clear();
      opcode = 7'b0010111; pc = 32'h1000; imm = 32'h2000; rd_addr = 5'd10;
      auipc_e = mk(1'b1, 1'b1, 32'h1000, 32'h2000, 4'b0000, 5'd10, 1'b1, 32'h0, 32'h1000, 1'b0);
      issue("auipc", auipc_e);

      for (int i = 0; i < 3; i++) begin
         @(negedge clk); clear();
         stall = 1'b1;
         set_rr(7'b0110011, 3'b000, 1'b1, 5'd3, 32'hFFFF0000 + i, 5'd4, 32'h5, 5'd9);
         pc = 32'h500 + i; imm = 32'h77;
         issue("stall_hold", auipc_e);
         #1 chk("in_ready_stall", {31'd0, in_ready}, 32'd0);
      end

      @(negedge clk); clear();
      stall = 1'b1; flush = 1'b1;
      issue("flush_stall", mk(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0));

      @(negedge clk); clear();
      set_rr(7'b1100011, 3'b110, 1'b0, 5'd1, 32'hFFFFFFFF, 5'd2, 32'd1, 5'd5); pc = 32'h30;
      issue("bltu", mk(1'b1, 1'b1, 32'hFFFFFFFF, 32'd1, 4'b0011, 5'd5, 1'b0, 32'd1, 32'h30, 1'b0));

      @(negedge clk); clear();
      set_rr(7'b1100011, 3'b000, 1'b0, 5'd1, 32'h8, 5'd2, 32'h8, 5'd0); pc = 32'h34;
      issue("beq", mk(1'b1, 1'b1, 32'h8, 32'h8, 4'b1000, 5'd0, 1'b0, 32'h8, 32'h34, 1'b0));

      @(negedge clk); clear();
      set_rr(7'b1100011, 3'b100, 1'b0, 5'd1, 32'h1, 5'd2, 32'h2, 5'd0); pc = 32'h38;
      issue("blt", mk(1'b1, 1'b1, 32'h1, 32'h2, 4'b0010, 5'd0, 1'b0, 32'h2, 32'h38, 1'b0));

      @(negedge clk); clear();
      set_rr(7'b1100011, 3'b010, 1'b0, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3);
      issue("branch_illegal", mk(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1));

      @(negedge clk); clear();
      opcode = 7'b1101111; pc = 32'h40; rd_addr = 5'd1; imm = 32'h800;
      issue("jal", mk(1'b1, 1'b1, 32'h40, 32'd4, 4'b0000, 5'd1, 1'b1, 32'h0, 32'h40, 1'b0));

      @(negedge clk); clear();
      set_rr(7'b0000011, 3'b010, 1'b0, 5'd2, 32'h100, 5'd0, 32'h0, 5'd6); imm = 32'h10; pc = 32'h44;
      issue("load", mk(1'b1, 1'b1, 32'h100, 32'h10, 4'b0000, 5'd6, 1'b1, 32'h0, 32'h44, 1'b0));

      @(negedge clk); clear();
      set_rr(7'b0100011, 3'b010, 1'b0, 5'd2, 32'h100, 5'd3, 32'hCAFE, 5'd7); imm = 32'h8; pc = 32'h48;
      exmem_wr_en = 1'b1; exmem_rd = 5'd3; exmem_data = 32'hBEEF;
      issue("store_fwd", mk(1'b1, 1'b1, 32'h100, 32'h8, 4'b0000, 5'd7, 1'b0, 32'hBEEF, 32'h48, 1'b0));

      @(negedge clk); clear();
      set_rr(7'b1111111, 3'b000, 1'b0, 5'd1, 32'h9, 5'd2, 32'hA, 5'd4); pc = 32'h4C; imm = 32'h5;
      issue("bad_opcode", mk(1'b1, 1'b1, 32'h0, 32'h0, 4'b0000, 5'd4, 1'b0, 32'hA, 32'h4C, 1'b1));

      @(negedge clk); clear();
      set_rr(7'b1111111, 3'b000, 1'b0, 5'd1, 32'h9, 5'd2, 32'hA, 5'd4); in_valid = 1'b0;
      issue("bubble", mk(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0));

      @(negedge clk); clear();
      opcode = 7'b0110111; imm = 32'h12345000; rd_addr = 5'd2; pc = 32'h80;
      issue("lui", mk(1'b1, 1'b1, 32'h0, 32'h12345000, 4'b0000, 5'd2, 1'b1, 32'h0, 32'h80, 1'b0));

      @(negedge clk); clear();
      flush = 1'b1; set_rr(7'b0110011, 3'b000, 1'b0, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3);
      issue("flush", mk(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0));

      @(negedge clk); clear();
      set_rr(7'b0110011, 3'b110, 1'b0, 5'd1, 32'hA0, 5'd2, 32'h0B, 5'd12); pc = 32'h88;
      issue("or", mk(1'b1, 1'b1, 32'hA0, 32'h0B, 4'b0110, 5'd12, 1'b1, 32'h0B, 32'h88, 1'b0));

      @(negedge clk); clear();
      reset = 1'b1; stall = 1'b1; flush = 1'b1;
      issue("reset_in_stall", mk(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0));

      @(negedge clk); clear();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (exp_q.size() > 0) begin
            @(negedge clk);
         end
      end
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
